// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite definitions for the master and any neighbouring blocks.
//
// Contents:
//   axi4l_state_t - transaction FSM states of m_axi4l_master
//   axi4l_resp_t  - AXI response codes (OKAY, EXOKAY, SLVERR, DECERR)
//   resp_is_err   - true for any response other than OKAY
package axi4l_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } axi4l_state_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi4l_resp_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/m_axi4l_master.sv
// AXI4-Lite master: turns a simple valid/ready command into a single AXI4-Lite
// read or write and returns the result on a valid/ready response port.
// Only one transaction is in flight at a time.
//
// Ports:
//   i_axi_clock, i_axi_areset          - clock, async active-high reset
//   i_cmd_* / o_cmd_ready              - command (write flag, addr, wdata, wstrb)
//   o_rsp_* / i_rsp_ready              - response (write flag, read data, resp)
//   o_axi_aw* / o_axi_w* / *_b*        - AXI write address, data, response
//   o_axi_ar* / *_rdata*, i_axi_rresp  - AXI read address and data
//   o_wr_count, o_rd_count, o_err_count - completed write/read/error counts
//                                         (only with M_AXI4L_MASTER_STATS_EN)
//
// Optional feature: define M_AXI4L_MASTER_STATS_EN to add the statistics
// counters; without it the block is otherwise identical.
module m_axi4l_master
  import axi4l_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    i_axi_clock,
  input  logic                    i_axi_areset,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_write,
  input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [DATA_WIDTH-1:0]   i_cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_cmd_wstrb,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic                    o_rsp_write,
  output logic [DATA_WIDTH-1:0]   o_rsp_data,
  output logic [1:0]              o_rsp_resp,
  output logic [ADDR_WIDTH-1:0]   o_axi_awaddr,
  output logic [2:0]              o_axi_awprot,
  output logic                    o_axi_awaddr_valid,
  input  logic                    i_axi_awaddr_ready,
  output logic [DATA_WIDTH-1:0]   o_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] o_axi_wstrb,
  output logic                    o_axi_wdata_valid,
  input  logic                    i_axi_wdata_ready,
  input  logic [1:0]              i_axi_bresp,
  input  logic                    i_axi_bvalid,
  output logic                    o_axi_bready,
  output logic [ADDR_WIDTH-1:0]   o_axi_araddr,
  output logic [3:0]              o_axi_arcache,
  output logic [2:0]              o_axi_arprot,
  output logic                    o_axi_araddr_valid,
  input  logic                    i_axi_araddr_ready,
  input  logic [DATA_WIDTH-1:0]   i_axi_rdata,
  input  logic [1:0]              i_axi_rresp,
  input  logic                    i_axi_rdata_valid,
  output logic                    o_axi_rdata_ready
`ifdef M_AXI4L_MASTER_STATS_EN
  ,
  output logic [15:0]             o_wr_count,
  output logic [15:0]             o_rd_count,
  output logic [15:0]             o_err_count
`endif
);

  axi4l_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    write_q;
  logic                    aw_done_q;
  logic                    w_done_q;
  logic [DATA_WIDTH-1:0]   rsp_data_q;
  logic [1:0]              rsp_resp_q;

  logic cmd_accept;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // Every output is a decode of the state plus registered payload, so an
  // asynchronous reset drops all VALID/READY lines in the same cycle.
  // AW and W each drop independently once their own handshake is recorded.
  assign o_cmd_ready        = (state_q == IDLE);
  assign o_axi_awaddr_valid = (state_q == WR_ADDR_DATA) && !aw_done_q;
  assign o_axi_wdata_valid  = (state_q == WR_ADDR_DATA) && !w_done_q;
  assign o_axi_bready       = (state_q == WR_RESP);
  assign o_axi_araddr_valid = (state_q == RD_ADDR);
  assign o_axi_rdata_ready  = (state_q == RD_DATA);
  assign o_rsp_valid        = (state_q == RSP);

  assign o_axi_awaddr  = addr_q;
  assign o_axi_araddr  = addr_q;
  assign o_axi_wdata   = wdata_q;
  assign o_axi_wstrb   = wstrb_q;
  assign o_axi_awprot  = 3'b000;
  assign o_axi_arprot  = 3'b000;
  assign o_axi_arcache = 4'b0000;
  assign o_rsp_write   = write_q;
  assign o_rsp_data    = rsp_data_q;
  assign o_rsp_resp    = rsp_resp_q;

  assign cmd_accept = i_cmd_valid && o_cmd_ready;
  assign aw_hs      = o_axi_awaddr_valid && i_axi_awaddr_ready;
  assign w_hs       = o_axi_wdata_valid && i_axi_wdata_ready;
  assign b_hs       = i_axi_bvalid && o_axi_bready;
  assign ar_hs      = o_axi_araddr_valid && i_axi_araddr_ready;
  assign r_hs       = i_axi_rdata_valid && o_axi_rdata_ready;

  // State register; reset abandons whatever transaction was in flight.
  always_ff @(posedge i_axi_clock or posedge i_axi_areset) begin
    if (i_axi_areset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. The write phase finishes once both AW and W have been
  // accepted, whether earlier (done flag) or on this very edge (handshake).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (cmd_accept) state_d = i_cmd_write ? WR_ADDR_DATA : RD_ADDR;
      WR_ADDR_DATA: if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_RESP;
      WR_RESP:      if (b_hs) state_d = RSP;
      RD_ADDR:      if (ar_hs) state_d = RD_DATA;
      RD_DATA:      if (r_hs) state_d = RSP;
      RSP:          if (i_rsp_ready) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  // Command payload is captured on acceptance and held for the whole
  // transaction, which keeps AXI payloads stable while VALID is high.
  // The response is captured from B or R and held until the handshake.
  always_ff @(posedge i_axi_clock or posedge i_axi_areset) begin
    if (i_axi_areset) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      write_q    <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_resp_q <= 2'b00;
    end else begin
      if (cmd_accept) begin
        addr_q    <= i_cmd_addr;
        wdata_q   <= i_cmd_wdata;
        wstrb_q   <= i_cmd_wstrb;
        write_q   <= i_cmd_write;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
      if (b_hs) begin
        rsp_data_q <= '0;
        rsp_resp_q <= i_axi_bresp;
      end
      if (r_hs) begin
        rsp_data_q <= i_axi_rdata;
        rsp_resp_q <= i_axi_rresp;
      end
    end
  end

`ifdef M_AXI4L_MASTER_STATS_EN
  logic [15:0] wr_count_q, rd_count_q, err_count_q;

  assign o_wr_count  = wr_count_q;
  assign o_rd_count  = rd_count_q;
  assign o_err_count = err_count_q;

  // Counters step on the edge that enters RSP (the B or R handshake) and
  // wrap naturally at 16 bits.
  always_ff @(posedge i_axi_clock or posedge i_axi_areset) begin
    if (i_axi_areset) begin
      wr_count_q  <= '0;
      rd_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      if (b_hs) wr_count_q <= wr_count_q + 16'd1;
      if (r_hs) rd_count_q <= rd_count_q + 16'd1;
      if ((b_hs && resp_is_err(i_axi_bresp)) || (r_hs && resp_is_err(i_axi_rresp)))
        err_count_q <= err_count_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_m_axi4l_master.sv
// Testbench for m_axi4l_master: a behavioural AXI4-Lite slave with
// configurable ready/response delays, a command driver and a response
// scoreboard. Statistics checks are compiled in with M_AXI4L_MASTER_STATS_EN.
module tb_m_axi4l_master;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          i_axi_clock = 1'b0;
  logic          i_axi_areset;
  logic          i_cmd_valid, o_cmd_ready, i_cmd_write;
  logic [AW-1:0] i_cmd_addr;
  logic [DW-1:0] i_cmd_wdata;
  logic [SW-1:0] i_cmd_wstrb;
  logic          o_rsp_valid, i_rsp_ready, o_rsp_write;
  logic [DW-1:0] o_rsp_data;
  logic [1:0]    o_rsp_resp;
  logic [AW-1:0] o_axi_awaddr, o_axi_araddr;
  logic [2:0]    o_axi_awprot, o_axi_arprot;
  logic [3:0]    o_axi_arcache;
  logic          o_axi_awaddr_valid, i_axi_awaddr_ready = 1'b0;
  logic [DW-1:0] o_axi_wdata;
  logic [SW-1:0] o_axi_wstrb;
  logic          o_axi_wdata_valid, i_axi_wdata_ready = 1'b0;
  logic [1:0]    i_axi_bresp = 2'b00;
  logic          i_axi_bvalid = 1'b0, o_axi_bready;
  logic          o_axi_araddr_valid, i_axi_araddr_ready = 1'b0;
  logic [DW-1:0] i_axi_rdata = '0;
  logic [1:0]    i_axi_rresp = 2'b00;
  logic          i_axi_rdata_valid = 1'b0, o_axi_rdata_ready;
`ifdef M_AXI4L_MASTER_STATS_EN
  logic [15:0]   o_wr_count, o_rd_count, o_err_count;
`endif

  m_axi4l_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_axi_clock(i_axi_clock), .i_axi_areset(i_axi_areset),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_write(o_rsp_write),
    .o_rsp_data(o_rsp_data), .o_rsp_resp(o_rsp_resp),
    .o_axi_awaddr(o_axi_awaddr), .o_axi_awprot(o_axi_awprot),
    .o_axi_awaddr_valid(o_axi_awaddr_valid), .i_axi_awaddr_ready(i_axi_awaddr_ready),
    .o_axi_wdata(o_axi_wdata), .o_axi_wstrb(o_axi_wstrb),
    .o_axi_wdata_valid(o_axi_wdata_valid), .i_axi_wdata_ready(i_axi_wdata_ready),
    .i_axi_bresp(i_axi_bresp), .i_axi_bvalid(i_axi_bvalid), .o_axi_bready(o_axi_bready),
    .o_axi_araddr(o_axi_araddr), .o_axi_arcache(o_axi_arcache), .o_axi_arprot(o_axi_arprot),
    .o_axi_araddr_valid(o_axi_araddr_valid), .i_axi_araddr_ready(i_axi_araddr_ready),
    .i_axi_rdata(i_axi_rdata), .i_axi_rresp(i_axi_rresp),
    .i_axi_rdata_valid(i_axi_rdata_valid), .o_axi_rdata_ready(o_axi_rdata_ready)
`ifdef M_AXI4L_MASTER_STATS_EN
    ,
    .o_wr_count(o_wr_count), .o_rd_count(o_rd_count), .o_err_count(o_err_count)
`endif
  );

  always #5 i_axi_clock = ~i_axi_clock;

  typedef struct packed {
    logic          write;
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } rsp_t;

  rsp_t expQ[$];
  int   totalCount = 0;
  int   badCount   = 0;

  // Slave configuration, set by the test sequence between transactions.
  int          awDelay = 0, wDelay = 0, bDelay = 0, arDelay = 0, rDelay = 0;
  logic [1:0]  bRespCfg = 2'b00, rRespCfg = 2'b00;
  logic [DW-1:0] rDataCfg = '0;

  // Slave internal state and observation counters.
  bit awWillHs = 0, wWillHs = 0, bWillHs = 0, arWillHs = 0, rWillHs = 0;
  bit awDone = 0, wDone = 0, arDone = 0;
  int bWait = 0, rWait = 0;
  int awValidCycles = 0, wValidCycles = 0, arValidCycles = 0;
  int breadyCycles = 0, bHsCount = 0;
  logic [AW-1:0] awAddrSeen = '0, arAddrSeen = '0;
  logic [DW-1:0] wDataSeen = '0;
  logic [SW-1:0] wStrbSeen = '0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    totalCount++;
    if (got !== exp) begin
      badCount++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clearMonitors();
    awValidCycles = 0; wValidCycles = 0; arValidCycles = 0;
    breadyCycles = 0; bHsCount = 0;
  endtask

  task automatic slaveReset();
    awWillHs = 0; wWillHs = 0; bWillHs = 0; arWillHs = 0; rWillHs = 0;
    awDone = 0; wDone = 0; arDone = 0; bWait = 0; rWait = 0;
    i_axi_awaddr_ready = 0; i_axi_wdata_ready = 0; i_axi_araddr_ready = 0;
    i_axi_bvalid = 0; i_axi_rdata_valid = 0;
  endtask

  // One slave step, run 1 time unit after each rising edge: retire the
  // handshakes that completed on that edge, then set up the next cycle.
  task automatic slaveStep();
    if (awWillHs) awDone = 1;
    if (wWillHs)  wDone  = 1;
    if (bWillHs) begin
      i_axi_bvalid = 0; bHsCount++; awDone = 0; wDone = 0; bWait = 0;
    end
    if (arWillHs) arDone = 1;
    if (rWillHs) begin
      i_axi_rdata_valid = 0; arDone = 0; rWait = 0;
    end
    awWillHs = 0; wWillHs = 0; bWillHs = 0; arWillHs = 0; rWillHs = 0;

    if (o_axi_awaddr_valid) begin
      awValidCycles++;
      i_axi_awaddr_ready = (awValidCycles > awDelay);
    end else i_axi_awaddr_ready = (awDelay == 0);
    if (o_axi_awaddr_valid && i_axi_awaddr_ready) begin
      awWillHs = 1; awAddrSeen = o_axi_awaddr;
    end

    if (o_axi_wdata_valid) begin
      wValidCycles++;
      i_axi_wdata_ready = (wValidCycles > wDelay);
    end else i_axi_wdata_ready = (wDelay == 0);
    if (o_axi_wdata_valid && i_axi_wdata_ready) begin
      wWillHs = 1; wDataSeen = o_axi_wdata; wStrbSeen = o_axi_wstrb;
    end

    if (awDone && wDone && !i_axi_bvalid) begin
      bWait++;
      if (bWait > bDelay) begin
        i_axi_bvalid = 1; i_axi_bresp = bRespCfg;
      end
    end
    if (o_axi_bready) breadyCycles++;
    bWillHs = i_axi_bvalid && o_axi_bready;

    if (o_axi_araddr_valid) begin
      arValidCycles++;
      i_axi_araddr_ready = (arValidCycles > arDelay);
    end else i_axi_araddr_ready = (arDelay == 0);
    if (o_axi_araddr_valid && i_axi_araddr_ready) begin
      arWillHs = 1; arAddrSeen = o_axi_araddr;
    end

    if (arDone && !i_axi_rdata_valid) begin
      rWait++;
      if (rWait > rDelay) begin
        i_axi_rdata_valid = 1; i_axi_rdata = rDataCfg; i_axi_rresp = rRespCfg;
      end
    end
    rWillHs = i_axi_rdata_valid && o_axi_rdata_ready;
  endtask

  always @(posedge i_axi_clock or posedge i_axi_areset) begin
    if (i_axi_areset) slaveReset();
    else begin
      #1;
      if (!i_axi_areset) slaveStep();
    end
  end

  task automatic pushExpect(input logic write);
    rsp_t e;
    e.write = write;
    e.data  = write ? '0 : rDataCfg;
    e.resp  = write ? bRespCfg : rRespCfg;
    expQ.push_back(e);
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic applyStimulus(input logic write, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input logic [SW-1:0] strb,
                               input bit keepValid);
    int cyc = 0;
    pushExpect(write);
    i_cmd_write = write; i_cmd_addr = addr; i_cmd_wdata = data; i_cmd_wstrb = strb;
    i_cmd_valid = 1;
    while (!o_cmd_ready && cyc < 50) begin
      @(negedge i_axi_clock); cyc++;
    end
    if (!o_cmd_ready) begin
      checkOutput("cmd_accept_timeout", 0, 1);
      i_cmd_valid = 0;
      return;
    end
    @(posedge i_axi_clock);
    @(negedge i_axi_clock);
    if (!keepValid) i_cmd_valid = 0;
  endtask

  // Waits for a response, optionally holds i_rsp_ready low for holdLow
  // cycles, then compares against the scoreboard and completes the handshake.
  task automatic collectResponse(input int holdLow, input bit watchCmd, output bit cmdEarly);
    int   cyc = 0;
    int   heldCnt = 0;
    rsp_t e;
    cmdEarly = 0;
    while (!o_rsp_valid && cyc < 100) begin
      if (watchCmd && o_cmd_ready) cmdEarly = 1;
      @(negedge i_axi_clock); cyc++;
    end
    if (!o_rsp_valid) begin
      checkOutput("rsp_timeout", 0, 1);
      return;
    end
    if (expQ.size() == 0) begin
      checkOutput("sb_empty", 0, 1);
      return;
    end
    e = expQ.pop_front();
    for (int i = 0; i < holdLow; i++) begin
      if (watchCmd && o_cmd_ready) cmdEarly = 1;
      if (o_rsp_valid && o_rsp_data == e.data && o_rsp_resp == e.resp) heldCnt++;
      @(negedge i_axi_clock);
    end
    if (holdLow > 0) checkOutput("rsp_hold", heldCnt, holdLow);
    if (watchCmd && o_cmd_ready) cmdEarly = 1;
    checkOutput("rsp_write", o_rsp_write, e.write);
    checkOutput("rsp_data", o_rsp_data, e.data);
    checkOutput("rsp_resp", o_rsp_resp, e.resp);
    i_rsp_ready = 1;
    @(negedge i_axi_clock);
    i_rsp_ready = 0;
    checkOutput("rsp_valid_drop", o_rsp_valid, 0);
  endtask

  initial begin
    bit early;
    int cyc;
    int seen;
    i_axi_areset = 1;
    i_cmd_valid = 0; i_cmd_write = 0; i_cmd_addr = '0; i_cmd_wdata = '0; i_cmd_wstrb = '0;
    i_rsp_ready = 0;
    repeat (2) @(negedge i_axi_clock);
    checkOutput("reset_cmd_ready", o_cmd_ready, 1);
    checkOutput("reset_valids", {o_axi_awaddr_valid, o_axi_wdata_valid, o_axi_araddr_valid,
                                 o_axi_bready, o_axi_rdata_ready, o_rsp_valid}, 0);
    i_axi_areset = 0;
    @(negedge i_axi_clock);

    $display("[TB] write with slave ready");
    clearMonitors();
    applyStimulus(1, 4'h4, 32'hDEADBEEF, 4'hF, 0);
    checkOutput("t1_aw_w_valid", {o_axi_awaddr_valid, o_axi_wdata_valid}, 2'b11);
    checkOutput("t1_awaddr", o_axi_awaddr, 4'h4);
    checkOutput("t1_wdata", o_axi_wdata, 32'hDEADBEEF);
    checkOutput("t1_prot_cache", {o_axi_awprot, o_axi_arprot, o_axi_arcache}, 0);
    collectResponse(0, 0, early);
    checkOutput("t1_aw_cycles", awValidCycles, 1);
    checkOutput("t1_w_cycles", wValidCycles, 1);
    checkOutput("t1_bready_cycles", breadyCycles, 1);
    checkOutput("t1_b_count", bHsCount, 1);
    checkOutput("t1_slave_wstrb", wStrbSeen, 4'hF);

    $display("[TB] write with delayed awaddr_ready");
    clearMonitors();
    awDelay = 3;
    applyStimulus(1, 4'hC, 32'hA5A50F0F, 4'h3, 0);
    collectResponse(0, 0, early);
    checkOutput("t2_aw_cycles", awValidCycles, 4);
    checkOutput("t2_w_cycles", wValidCycles, 1);
    checkOutput("t2_b_count", bHsCount, 1);
    checkOutput("t2_slave_awaddr", awAddrSeen, 4'hC);
    checkOutput("t2_slave_wdata", wDataSeen, 32'hA5A50F0F);
    checkOutput("t2_slave_wstrb", wStrbSeen, 4'h3);
    awDelay = 0;

    $display("[TB] read with two wait cycles");
    clearMonitors();
    rDelay = 2; rDataCfg = 32'h12345678; rRespCfg = 2'b00;
    applyStimulus(0, 4'h8, 32'h0, 4'h0, 0);
    checkOutput("t3_ar_valid", o_axi_araddr_valid, 1);
    checkOutput("t3_araddr", o_axi_araddr, 4'h8);
    collectResponse(0, 0, early);
    checkOutput("t3_slave_araddr", arAddrSeen, 4'h8);

    $display("[TB] read with SLVERR and held response");
    clearMonitors();
    arDelay = 1; rDelay = 0; rDataCfg = 32'hCAFEF00D; rRespCfg = 2'b10;
    applyStimulus(0, 4'h2, 32'h0, 4'h0, 0);
    collectResponse(5, 0, early);
    checkOutput("t4_ar_cycles", arValidCycles, 2);
    arDelay = 0; rRespCfg = 2'b00;
`ifdef M_AXI4L_MASTER_STATS_EN
    checkOutput("t4_wr_count", o_wr_count, 2);
    checkOutput("t4_rd_count", o_rd_count, 2);
    checkOutput("t4_err_count", o_err_count, 1);
`endif

    $display("[TB] reset while waiting for B");
    clearMonitors();
    bDelay = 6;
    applyStimulus(1, 4'h1, 32'h11112222, 4'hF, 0);
    cyc = 0;
    while (!o_axi_bready && cyc < 20) begin
      @(negedge i_axi_clock); cyc++;
    end
    checkOutput("t5_in_wr_resp", o_axi_bready, 1);
    #2 i_axi_areset = 1;
    #1;
    checkOutput("t5_valids_ready", {o_axi_awaddr_valid, o_axi_wdata_valid, o_axi_araddr_valid,
                                    o_axi_bready, o_axi_rdata_ready, o_rsp_valid}, 0);
    checkOutput("t5_cmd_ready", o_cmd_ready, 1);
    checkOutput("t5_payload_zero", {o_axi_awaddr, o_axi_wdata, o_axi_wstrb, o_rsp_data, o_rsp_resp}, 0);
`ifdef M_AXI4L_MASTER_STATS_EN
    checkOutput("t5_counts_zero", {o_wr_count, o_rd_count, o_err_count}, 0);
`endif
    if (expQ.size() > 0) void'(expQ.pop_back());
    @(negedge i_axi_clock);
    i_axi_areset = 0;
    bDelay = 0;
    seen = 0;
    repeat (8) begin
      @(negedge i_axi_clock);
      if (o_rsp_valid) seen++;
    end
    checkOutput("t5_no_rsp", seen, 0);

    $display("[TB] back-to-back write then read");
    clearMonitors();
    rDataCfg = 32'h55AA33CC;
    applyStimulus(1, 4'h6, 32'h0BADF00D, 4'hF, 1);
    i_cmd_write = 0; i_cmd_addr = 4'hA;
    pushExpect(0);
    collectResponse(0, 1, early);
    checkOutput("t6_no_early_accept", early, 0);
    checkOutput("t6_cmd_ready_idle", o_cmd_ready, 1);
    @(posedge i_axi_clock);
    @(negedge i_axi_clock);
    i_cmd_valid = 0;
    checkOutput("t6_read_started", o_axi_araddr_valid, 1);
    collectResponse(0, 0, early);
    checkOutput("t6_slave_araddr", arAddrSeen, 4'hA);
    checkOutput("t6_slave_wdata", wDataSeen, 32'h0BADF00D);
`ifdef M_AXI4L_MASTER_STATS_EN
    checkOutput("t6_wr_count", o_wr_count, 1);
    checkOutput("t6_rd_count", o_rd_count, 1);
    checkOutput("t6_err_count", o_err_count, 0);
`endif
    checkOutput("sb_drained", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
